// File: rtl/max_result_collector.sv
// Collects per-lane MAX results and drains them round-robin into register-file writes.
// Optional MAX_COLLECT_STATS_EN adds a 16-bit accepted-write counter output (wr_count).

module max_collect_slot #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_i,
    input  logic              grant_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0] dst_i,
    output logic              pending_o,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] dst_o,
    output logic              ovf_o
);
    logic              pending_q, pending_d;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] dst_q;
    logic              capture;

    // A slot being granted this cycle is free, so a same-cycle strobe refills it.
    assign capture   = done_i & (~pending_q | grant_i);
    assign pending_d = capture | (pending_q & ~grant_i);
    assign ovf_o     = done_i & pending_q & ~grant_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
            data_q    <= '0;
            dst_q     <= '0;
        end else begin
            pending_q <= pending_d;
            if (capture) begin
                data_q <= data_i;
                dst_q  <= dst_i;
            end
        end
    end

    assign pending_o = pending_q;
    assign data_o    = data_q;
    assign dst_o     = dst_q;
endmodule

module max_result_collector #(
    parameter int LANES  = 32,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        lane_done,
    input  logic [LANES*DATA_W-1:0] lane_data,
    input  logic [LANES*ADDR_W-1:0] lane_dst,
    output logic [LANES-1:0]        lane_busy,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic [4:0]              wr_lane,
    output logic                    err_overflow,
`ifdef MAX_COLLECT_STATS_EN
    output logic [15:0]             wr_count,
`endif
    output logic                    idle
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0]             pend, grant, ovf;
    logic [LANES-1:0][DATA_W-1:0] s_data;
    logic [LANES-1:0][ADDR_W-1:0] s_dst;

    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [4:0]        wr_lane_q, wr_lane_d;
    logic [LW-1:0]     last_q, last_d;
    logic              err_q, err_d;

    logic          load_en, any_pend;
    logic [LW-1:0] gnt_idx;

    assign load_en = ~wr_valid_q | wr_ready;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_slot
            assign grant[i] = load_en & any_pend & (gnt_idx == LW'(i));
            max_collect_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot (
                .clk       (clk),
                .rst       (rst),
                .done_i    (lane_done[i]),
                .grant_i   (grant[i]),
                .data_i    (lane_data[i*DATA_W +: DATA_W]),
                .dst_i     (lane_dst[i*ADDR_W +: ADDR_W]),
                .pending_o (pend[i]),
                .data_o    (s_data[i]),
                .dst_o     (s_dst[i]),
                .ovf_o     (ovf[i])
            );
        end
    endgenerate

    // First pending lane scanning upward from the lane after the last grant.
    always_comb begin
        logic [LW-1:0] cand;
        cand     = '0;
        gnt_idx  = '0;
        any_pend = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            cand = LW'((int'(last_q) + k + 1) % LANES);
            if (!any_pend && pend[cand]) begin
                gnt_idx  = cand;
                any_pend = 1'b1;
            end
        end
    end

    always_comb begin
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_lane_d  = wr_lane_q;
        last_d     = last_q;
        err_d      = err_q | (|ovf);
        if (load_en) begin
            wr_valid_d = any_pend;
            if (any_pend) begin
                wr_addr_d = s_dst[gnt_idx];
                wr_data_d = s_data[gnt_idx];
                wr_lane_d = 5'(gnt_idx);
                last_d    = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_lane_q  <= '0;
            last_q     <= LW'(LANES - 1);
            err_q      <= 1'b0;
        end else begin
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_lane_q  <= wr_lane_d;
            last_q     <= last_d;
            err_q      <= err_d;
        end
    end

`ifdef MAX_COLLECT_STATS_EN
    logic [15:0] cnt_q, cnt_d;
    assign cnt_d = (wr_valid_q & wr_ready) ? cnt_q + 16'd1 : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign wr_count = cnt_q;
`endif

    assign lane_busy    = pend;
    assign wr_valid     = wr_valid_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign wr_lane      = wr_lane_q;
    assign err_overflow = err_q;
    assign idle         = ~(|pend) & ~wr_valid_q;
endmodule

// File: tb/tb_max_result_collector.sv
// Scoreboard bench for max_result_collector: stimulus pushes expected writes, a monitor pops them.
module tb_max_result_collector;
    localparam int LANES  = 32;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [LANES-1:0]        lane_done;
    logic [LANES*DATA_W-1:0] lane_data;
    logic [LANES*ADDR_W-1:0] lane_dst;
    logic [LANES-1:0]        lane_busy;
    logic                    wr_valid, wr_ready;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic [4:0]              wr_lane;
    logic                    err_overflow, idle;
`ifdef MAX_COLLECT_STATS_EN
    logic [15:0]             wr_count;
`endif

    max_result_collector #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .lane_done    (lane_done),
        .lane_data    (lane_data),
        .lane_dst     (lane_dst),
        .lane_busy    (lane_busy),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_lane      (wr_lane),
        .err_overflow (err_overflow),
`ifdef MAX_COLLECT_STATS_EN
        .wr_count     (wr_count),
`endif
        .idle         (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]        lane;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   acc_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int i, input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a);
        lane_done[i] = 1'b1;
        lane_data[i*DATA_W +: DATA_W] = d;
        lane_dst[i*ADDR_W +: ADDR_W]  = a;
    endtask

    task automatic expect_wr(input int i, input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a);
        exp_t e;
        e.lane = 5'(i);
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        acc_cnt = 0;
    endtask

    // Monitor: every accepted write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && wr_valid && wr_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_lane", {27'd0, wr_lane}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_lane", {27'd0, wr_lane}, {27'd0, e.lane});
                chk("wr_addr", {24'd0, wr_addr}, {24'd0, e.addr});
                chk("wr_data", wr_data, e.data);
            end
            acc_cnt++;
        end
    end

    initial begin
        rst = 1'b1; lane_done = '0; lane_data = '0; lane_dst = '0; wr_ready = 1'b0;
        step(); step();
        rst = 1'b0;

        // Reset state
        chk("rst_lane_busy", lane_busy, 32'd0);
        chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_wr_lane", {27'd0, wr_lane}, 32'd0);
        chk("rst_err", {31'd0, err_overflow}, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
`ifdef MAX_COLLECT_STATS_EN
        chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
`endif

        // Single write, 2-cycle latency
        wr_ready = 1'b1;
        strobe(3, 32'h0000_00A5, 8'h12);
        expect_wr(3, 32'h0000_00A5, 8'h12);
        step(); lane_done = '0;
        chk("t1_busy3_set", {31'd0, lane_busy[3]}, 32'd1);
        chk("t1_valid_lat1", {31'd0, wr_valid}, 32'd0);
        step();
        chk("t1_valid_lat2", {31'd0, wr_valid}, 32'd1);
        chk("t1_busy3_clr", {31'd0, lane_busy[3]}, 32'd0);
        step();
        chk("t1_valid_done", {31'd0, wr_valid}, 32'd0);
        chk("t1_idle", {31'd0, idle}, 32'd1);
        chk("t1_queue_empty", exp_q.size(), 32'd0);

        // All lanes at once, drained 0..31 without gaps
        do_reset();
        wr_ready = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            strobe(i, DATA_W'(i), ADDR_W'(8'h40 + i));
            expect_wr(i, DATA_W'(i), ADDR_W'(8'h40 + i));
        end
        step(); lane_done = '0;
        chk("t2_all_busy", lane_busy, 32'hFFFF_FFFF);
        step();
        for (int i = 0; i < LANES; i++) begin
            chk("t2_nogap", {31'd0, wr_valid}, 32'd1);
            step();
        end
        chk("t2_drained", {31'd0, wr_valid}, 32'd0);
        chk("t2_err", {31'd0, err_overflow}, 32'd0);
        chk("t2_queue_empty", exp_q.size(), 32'd0);
`ifdef MAX_COLLECT_STATS_EN
        chk("t2_wr_count", {16'd0, wr_count}, 32'd32);
`endif

        // Backpressure holds lane-5 payload stable
        do_reset();
        wr_ready = 1'b0;
        strobe(5, 32'h5555_0005, 8'h05);
        strobe(9, 32'h9999_0009, 8'h09);
        expect_wr(5, 32'h5555_0005, 8'h05);
        expect_wr(9, 32'h9999_0009, 8'h09);
        step(); lane_done = '0;
        step();
        for (int c = 0; c < 4; c++) begin
            chk("t3_hold_valid", {31'd0, wr_valid}, 32'd1);
            chk("t3_hold_data", wr_data, 32'h5555_0005);
            chk("t3_hold_lane", {27'd0, wr_lane}, 32'd5);
            step();
        end
        wr_ready = 1'b1;
        step(); step();
        chk("t3_drained", {31'd0, wr_valid}, 32'd0);
        chk("t3_queue_empty", exp_q.size(), 32'd0);

        // Overflow: lane 7 strobed twice while the output stage is stalled
        do_reset();
        wr_ready = 1'b0;
        strobe(0, 32'h0000_0C0C, 8'h20);
        expect_wr(0, 32'h0000_0C0C, 8'h20);
        step(); lane_done = '0;
        step();
        strobe(7, 32'h1, 8'h77);
        expect_wr(7, 32'h1, 8'h77);
        step(); lane_done = '0;
        chk("t4_no_err_yet", {31'd0, err_overflow}, 32'd0);
        strobe(7, 32'h2, 8'h78);
        step(); lane_done = '0;
        chk("t4_err_set", {31'd0, err_overflow}, 32'd1);
        step(); step();
        chk("t4_err_sticky", {31'd0, err_overflow}, 32'd1);
        wr_ready = 1'b1;
        step(); step(); step();
        chk("t4_err_after_drain", {31'd0, err_overflow}, 32'd1);
        chk("t4_queue_empty", exp_q.size(), 32'd0);

        // Refill in the grant cycle
        do_reset();
        chk("t5_err_cleared", {31'd0, err_overflow}, 32'd0);
        wr_ready = 1'b1;
        strobe(2, 32'h0000_00AA, 8'h22);
        expect_wr(2, 32'h0000_00AA, 8'h22);
        step();
        strobe(2, 32'h0000_0055, 8'h23);
        expect_wr(2, 32'h0000_0055, 8'h23);
        step(); lane_done = '0;
        chk("t5_busy_refilled", {31'd0, lane_busy[2]}, 32'd1);
        chk("t5_first_data", wr_data, 32'h0000_00AA);
        step(); step();
        chk("t5_err", {31'd0, err_overflow}, 32'd0);
        chk("t5_queue_empty", exp_q.size(), 32'd0);

        // Reset mid-drain discards pending lanes and the output entry
        do_reset();
        wr_ready = 1'b1;
        for (int i = 0; i < 10; i++) strobe(i, 32'hD000_0000 + DATA_W'(i), ADDR_W'(8'h80 + i));
        expect_wr(0, 32'hD000_0000, 8'h80);
        step(); lane_done = '0;
        step();
        step();
        wr_ready = 1'b0;
        step();
        chk("t6_pre_rst_busy", lane_busy, 32'h0000_03FC);
        chk("t6_queue_empty_pre", exp_q.size(), 32'd0);
        rst = 1'b1;
        strobe(12, 32'hBAD0_000C, 8'hCC);
        step();
        rst = 1'b0; lane_done = '0; acc_cnt = 0;
        chk("t6_busy", lane_busy, 32'd0);
        chk("t6_valid", {31'd0, wr_valid}, 32'd0);
        chk("t6_idle", {31'd0, idle}, 32'd1);
`ifdef MAX_COLLECT_STATS_EN
        chk("t6_wr_count_rst", {16'd0, wr_count}, 32'd0);
`endif
        wr_ready = 1'b1;
        for (int c = 0; c < 5; c++) step();
        chk("t6_no_writes", acc_cnt, 32'd0);
        chk("t6_still_idle", {31'd0, idle}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/max_result_collector.md
# max_result_collector

Write-back side of the MAX command path: collects results from the 32 parallel max lanes and serializes them into register-file writes. Each lane deposits one result plus its destination register index. The collector holds it until a round-robin arbiter drains it over a valid/ready write port. Per-lane busy flags tell the dispatcher which lanes may take a new command.

## Interface
Parameters:
- LANES, 32, number of max lanes
- DATA_W, 32, result width
- ADDR_W, 8, register index width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- lane_done  in  LANES  per-lane one-cycle result strobe
- lane_data  in  LANES*DATA_W  lane i result at bits [i*DATA_W +: DATA_W]
- lane_dst  in  LANES*ADDR_W  lane i destination at bits [i*ADDR_W +: ADDR_W]
- lane_busy  out  LANES  lane holds an undrained result
- wr_valid  out  1  write request to register file
- wr_ready  in  1  register file accepts write
- wr_addr  out  ADDR_W  destination register index
- wr_data  out  DATA_W  value to write
- wr_lane  out  5  lane index of current write (debug/scoreboard)
- err_overflow  out  1  sticky: lane_done arrived while that lane was busy and not being granted
- idle  out  1  no lane busy and wr_valid low

## Operation
- Per-lane slot: pending bit (drives lane_busy), DATA_W data register, ADDR_W dst register.
- Capture: slot i loads lane_data/lane_dst and sets pending when lane_done[i] is high and either:
  - pending[i]==0, or
  - lane i is granted in the same cycle (free-and-refill; pending stays 1, new payload).
- Overflow: lane_done[i] with pending[i]==1 and no grant to lane i.
  - New payload dropped; old payload kept.
  - err_overflow set, cleared only by rst.
- Output register: one entry (wr_valid, wr_addr, wr_data, wr_lane).
  - Load enable = !wr_valid | wr_ready.
- Arbiter: when load enable is true and any pending bit is set, grant the first pending lane scanning from last_grant+1 upward, wrapping LANES-1 -> 0.
  - On grant: copy slot to output register, clear pending (unless refilled), set wr_valid=1, last_grant=granted lane.
  - On load enable with nothing pending: wr_valid=0.
- Write accepted on cycle where wr_valid & wr_ready. Output payload is held stable while wr_valid & !wr_ready.
- No combinational path lane_done -> wr_* or wr_ready -> lane_busy; lane_busy is registered.
- Back-to-back: with wr_ready held high and multiple lanes pending, one write per cycle.

## Timing
- Reset values: lane_busy=0, wr_valid=0, wr_addr=0, wr_data=0, wr_lane=0, err_overflow=0, idle=1, last_grant=LANES-1 (lane 0 served first).
- lane_done[i] sampled at edge N:
  - lane_busy[i]=1 after edge N.
  - Earliest grant at edge N+1: wr_valid=1 after N+1.
  - lane_busy[i] returns to 0 after N+1 if granted and not refilled.
- Latency done -> wr_valid: 2 cycles with an empty output stage.
- Fairness: a pending lane waits at most LANES-1 grants.
- rst mid-operation:
  - All pending results and the output entry are discarded.
  - Outputs return to reset values on the next edge.
  - lane_done in the reset cycle is ignored.
- All LANES lanes done in the same cycle: all captured, drained in order 0..31 (from reset state), 32 writes.

## Configuration
- MAX_COLLECT_STATS_EN defined:
  - Adds output wr_count (16 bits), reset 0.
  - Increments on each accepted write (wr_valid & wr_ready).
  - Wraps 0xFFFF -> 0x0000.
- Undefined: wr_count port and counter absent; all other behaviour identical.

## Test plan
- After rst: lane_done[3]=1, data 0x0000_00A5, dst 0x12; wr_ready=1 -> wr_valid high exactly 2 cycles after the strobe with wr_addr=0x12, wr_data=0xA5, wr_lane=3; lane_busy[3] clears; idle returns to 1.
- All 32 lanes strobe in one cycle, data=lane index, dst=0x40+i, wr_ready=1 -> 32 consecutive writes, lanes 0..31 in order, no gaps; err_overflow stays 0.
- Backpressure: two pending lanes (5, 9), wr_ready=0 for 4 cycles -> wr_valid=1 and lane-5 payload stable for all 4 cycles. Release wr_ready -> lane 5 then lane 9 written.
- Overflow: lane 7 strobed twice (data 0x1 then 0x2) while wr_ready=0 -> err_overflow=1 and stays 1. Later write carries 0x1.
- Refill on grant: lane 2 pending; strobe lane 2 (data 0x55) in its grant cycle -> first write carries old data, second write carries 0x55, err_overflow=0.
- Reset mid-drain: 10 lanes pending, assert rst 1 cycle -> lane_busy=0, wr_valid=0, no further writes. With MAX_COLLECT_STATS_EN: wr_count=0 after reset, and equals number of accepted writes otherwise.
